// File: rtl/smc_cfreg_bank_if.sv
// Register-access bus for the SMC config register bank.
// The master drives strobes, address and write data; the slave returns registered responses.
interface smc_cfreg_bank_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              selreg;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              wr_err;

  modport master (
    output selreg, wr_en, addr, wdata,
    input  rdata, rvalid, wr_err
  );

  modport slave (
    input  selreg, wr_en, addr, wdata,
    output rdata, rvalid, wr_err
  );
endinterface

// File: rtl/smc_cfreg_bank.sv
// SMC config register bank: per-CS shadow registers committed to active registers once the SMC is idle.
// Optional SMC_CFREG_PARITY_EN adds even parity on the active registers and a sticky par_err output.
module smc_cfreg_bank #(
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned ADDR_W    = 3,
  parameter logic [31:0] RESET_CFG = 32'hC000_0001
) (
  input  logic                   hclk,
  input  logic                   n_sys_reset,
  smc_cfreg_bank_if.slave        bus,
  input  logic                   commit,
  input  logic                   smc_idle,
  output logic                   commit_busy,
  output logic                   commit_done,
  output logic [NUM_CS*32-1:0]   cs_config
`ifdef SMC_CFREG_PARITY_EN
  ,
  output logic                   par_err
`endif
);

`ifdef SMC_CFREG_PARITY_EN
  localparam logic PAR_CAP = 1'b1;
`else
  localparam logic PAR_CAP = 1'b0;
`endif

  localparam logic [31:0] CAP_WORD = {1'b1, 1'b1, PAR_CAP, 21'h0, 8'(NUM_CS)};
  localparam logic [ADDR_W-1:0] CAP_ADDR = ADDR_W'(NUM_CS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] shadow [NUM_CS];
  logic [31:0] active [NUM_CS];
  logic [31:0] rd_word;
  logic        wr_req;
  logic        wr_ok;

  // ---------------------------------------------------------------------------
  // Commit FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    commit_busy = 1'b1;
    commit_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        commit_busy = 1'b0;
        if (commit) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (smc_idle) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        commit_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register access
  // ---------------------------------------------------------------------------
  // Shadows are frozen for the whole commit, so a write is accepted only from IDLE;
  // a write in the same IDLE cycle as commit therefore lands before APPLY copies it.
  assign wr_req = bus.selreg & bus.wr_en;
  assign wr_ok  = wr_req & (bus.addr < CAP_ADDR) & ~commit_busy;

  always_comb begin
    rd_word = '0;
    if (bus.addr == CAP_ADDR) rd_word = CAP_WORD;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (bus.addr == ADDR_W'(i)) rd_word = shadow[i];
    end
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      for (int unsigned i = 0; i < NUM_CS; i++) shadow[i] <= RESET_CFG;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        if (bus.addr == ADDR_W'(i)) shadow[i] <= bus.wdata;
      end
    end
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.rvalid <= bus.selreg & ~bus.wr_en;
      bus.wr_err <= wr_req & ~wr_ok;
      if (bus.selreg && !bus.wr_en) bus.rdata <= rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Active registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      for (int unsigned i = 0; i < NUM_CS; i++) active[i] <= RESET_CFG;
    end else if (state_q == ST_APPLY) begin
      for (int unsigned i = 0; i < NUM_CS; i++) active[i] <= shadow[i];
    end
  end

  always_comb begin
    cs_config = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) cs_config[32*i +: 32] = active[i];
  end

`ifdef SMC_CFREG_PARITY_EN
  logic [NUM_CS-1:0] active_par;
  logic [NUM_CS-1:0] par_bad;

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      for (int unsigned i = 0; i < NUM_CS; i++) active_par[i] <= ^RESET_CFG;
    end else if (state_q == ST_APPLY) begin
      for (int unsigned i = 0; i < NUM_CS; i++) active_par[i] <= ^shadow[i];
    end
  end

  always_comb begin
    par_bad = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) par_bad[i] = (^active[i]) ^ active_par[i];
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      par_err <= 1'b0;
    end else if (|par_bad) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_smc_cfreg_bank.sv
// Directed self-checking bench for smc_cfreg_bank (NUM_CS=4, ADDR_W=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_smc_cfreg_bank;
  localparam int unsigned NUM_CS = 4;
  localparam int unsigned ADDR_W = 3;
  localparam logic [31:0] RST_V  = 32'hC000_0001;
  localparam logic [31:0] CAP_V  = 32'hC000_0004;

  logic hclk        = 1'b0;
  logic n_sys_reset = 1'b1;
  logic commit      = 1'b0;
  logic smc_idle    = 1'b0;
  logic commit_busy;
  logic commit_done;
  logic [NUM_CS*32-1:0] cs_config;
`ifdef SMC_CFREG_PARITY_EN
  logic par_err;
`endif

  int checks = 0;
  int errors = 0;

  smc_cfreg_bank_if #(.ADDR_W(ADDR_W)) bus ();

  smc_cfreg_bank #(
    .NUM_CS   (NUM_CS),
    .ADDR_W   (ADDR_W),
    .RESET_CFG(RST_V)
  ) dut (
    .hclk       (hclk),
    .n_sys_reset(n_sys_reset),
    .bus        (bus),
    .commit     (commit),
    .smc_idle   (smc_idle),
    .commit_busy(commit_busy),
    .commit_done(commit_done),
    .cs_config  (cs_config)
`ifdef SMC_CFREG_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus;
    bus.selreg = 1'b0;
    bus.wr_en  = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
  endtask

  task automatic test_reset;
    idle_bus();
    #2 n_sys_reset = 1'b0;
    tick();
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", commit_busy); end
    checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", commit_done); end
    checks++; if (bus.rvalid !== 1'b0 || bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: rvalid %b wr_err %b expected 0 0", bus.rvalid, bus.wr_err); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    checks++; if (cs_config !== {NUM_CS{RST_V}}) begin errors++; $display("FAIL reset_cs_config: got %h expected %h", cs_config, {NUM_CS{RST_V}}); end
    #3 n_sys_reset = 1'b1;
    tick();
    for (int i = 0; i <= int'(NUM_CS); i++) begin
      logic [31:0] exp;
      exp = (i == int'(NUM_CS)) ? CAP_V : RST_V;
      bus.selreg = 1'b1; bus.wr_en = 1'b0; bus.addr = ADDR_W'(i);
      tick();
      idle_bus();
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin errors++; $display("FAIL reset_read%0d: rvalid %b rdata %h expected 1 %h", i, bus.rvalid, bus.rdata, exp); end
      tick();
      checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== exp) begin errors++; $display("FAIL reset_read%0d_pulse: rvalid %b rdata %h expected 0 %h (held)", i, bus.rvalid, bus.rdata, exp); end
    end
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.selreg = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic read_reg(input logic [ADDR_W-1:0] a);
    bus.selreg = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
    tick();
    idle_bus();
  endtask

  task automatic test_write_read;
    write_reg(3'd2, 32'h1234_5678);
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_accept: wr_err %b expected 0", bus.wr_err); end
    read_reg(3'd2);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback: rvalid %b rdata %h expected 1 12345678", bus.rvalid, bus.rdata); end
    checks++; if (cs_config[95:64] !== RST_V) begin errors++; $display("FAIL wr_no_commit: cs2 %h expected %h", cs_config[95:64], RST_V); end
  endtask

  task automatic test_commit_wait;
    smc_idle = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++; if (commit_busy !== 1'b1 || commit_done !== 1'b0) begin errors++; $display("FAIL wait_busy%0d: busy %b done %b expected 1 0", c, commit_busy, commit_done); end
      if (c == 3) begin
        write_reg(3'd2, 32'hDEAD_BEEF);
        checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wait_wr_err: wr_err %b expected 1", bus.wr_err); end
      end else if (c == 5) begin
        read_reg(3'd2);
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL wait_shadow_frozen: rdata %h expected 12345678", bus.rdata); end
      end else begin
        tick();
      end
    end
    checks++; if (cs_config[95:64] !== RST_V) begin errors++; $display("FAIL wait_cs_old: cs2 %h expected %h", cs_config[95:64], RST_V); end
    smc_idle = 1'b1;
    tick();
    checks++; if (commit_busy !== 1'b1 || cs_config[95:64] !== RST_V) begin errors++; $display("FAIL apply_state: busy %b cs2 %h expected 1 %h", commit_busy, cs_config[95:64], RST_V); end
    tick();
    checks++; if (commit_done !== 1'b1 || cs_config[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL done_state: done %b cs2 %h expected 1 12345678", commit_done, cs_config[95:64]); end
    checks++; if (cs_config[63:0] !== {2{RST_V}} || cs_config[127:96] !== RST_V) begin errors++; $display("FAIL done_others: cs_config %h", cs_config); end
    tick();
    checks++; if (commit_done !== 1'b0 || commit_busy !== 1'b0) begin errors++; $display("FAIL back_idle: done %b busy %b expected 0 0", commit_done, commit_busy); end
  endtask

  task automatic test_bad_addr;
    write_reg(3'd4, 32'h5555_AAAA);
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_cap: wr_err %b expected 1", bus.wr_err); end
    tick();
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse: wr_err %b expected 0", bus.wr_err); end
    write_reg(3'd7, 32'h5555_AAAA);
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_addr7: wr_err %b expected 1", bus.wr_err); end
    read_reg(3'd7);
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rd_addr7: rvalid %b rdata %h expected 1 0", bus.rvalid, bus.rdata); end
    read_reg(3'd4);
    checks++; if (bus.rdata !== CAP_V) begin errors++; $display("FAIL rd_cap_after_wr: rdata %h expected %h", bus.rdata, CAP_V); end
  endtask

  task automatic test_back_to_back;
    smc_idle = 1'b1;
    bus.selreg = 1'b1; bus.wr_en = 1'b1; bus.addr = 3'd1; bus.wdata = 32'hA5A5_0001;
    commit = 1'b1;
    tick();
    idle_bus();
    checks++; if (bus.wr_err !== 1'b0 || commit_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: wr_err %b busy %b expected 0 1", bus.wr_err, commit_busy); end
    checks++; if (cs_config[63:32] !== RST_V) begin errors++; $display("FAIL b2b_cs1_t1: got %h expected %h", cs_config[63:32], RST_V); end
    tick();
    commit = 1'b0;
    checks++; if (cs_config[63:32] !== RST_V) begin errors++; $display("FAIL b2b_cs1_t2: got %h expected %h", cs_config[63:32], RST_V); end
    tick();
    checks++; if (cs_config[63:32] !== 32'hA5A5_0001 || commit_done !== 1'b1) begin errors++; $display("FAIL b2b_applied: cs1 %h done %b expected a5a50001 1", cs_config[63:32], commit_done); end
    tick();
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b expected 0", commit_busy); end
    tick();
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue: busy %b expected 0", commit_busy); end
  endtask

  task automatic test_reset_mid_commit;
    write_reg(3'd0, 32'h1111_2222);
    smc_idle = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++; if (commit_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: busy %b expected 1", commit_busy); end
    n_sys_reset = 1'b0;
    #1;
    checks++; if (commit_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: busy %b expected 0", commit_busy); end
    checks++; if (cs_config !== {NUM_CS{RST_V}}) begin errors++; $display("FAIL rst_mid_cs: got %h expected %h", cs_config, {NUM_CS{RST_V}}); end
    #3 n_sys_reset = 1'b1;
    smc_idle = 1'b1;
    tick();
    tick();
    checks++; if (commit_busy !== 1'b0 || cs_config !== {NUM_CS{RST_V}}) begin errors++; $display("FAIL rst_mid_lost: busy %b cs %h", commit_busy, cs_config); end
    read_reg(3'd0);
    checks++; if (bus.rdata !== RST_V) begin errors++; $display("FAIL rst_mid_shadow: rdata %h expected %h", bus.rdata, RST_V); end
  endtask

`ifdef SMC_CFREG_PARITY_EN
  task automatic test_parity;
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clean: par_err %b expected 0", par_err); end
    read_reg(3'd4);
    checks++; if (bus.rdata !== 32'hE000_0004) begin errors++; $display("FAIL par_cap: rdata %h expected e0000004", bus.rdata); end
    force dut.active_par[0] = 1'b0;
    tick();
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_detect: par_err %b expected 1", par_err); end
    release dut.active_par[0];
    tick();
    tick();
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky: par_err %b expected 1", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_commit_wait();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_commit();
`ifdef SMC_CFREG_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
